// File: rtl/zh_anf_degree.sv
// Serial ANF scanner: reports algebraic degree, monomial count, zero and affine flags.
// Optional macro ZH_WEIGHT_EN builds the monomial counter; otherwise weight reads 0.
module zh_anf_degree #(
   parameter  int N_VARS = 3,
   localparam int W      = 2**N_VARS,
   localparam int DW     = $clog2(N_VARS+1),
   localparam int WW     = $clog2(W+1),
   localparam int IW     = $clog2(W)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [0:W-1]  anf,
   output logic          out_valid,
   input  logic          out_ack,
   output logic [DW-1:0] degree,
   output logic [WW-1:0] weight,
   output logic          is_zero,
   output logic          is_affine
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state, state_nxt;
   logic [0:W-1]    anf_q;
   logic [IW-1:0]   idx;
   logic [DW-1:0]   deg_q, deg_nxt, pc;
   logic            any_q, any_nxt, bit_cur, last;
   logic            zero_q, affine_q;

   function automatic logic [DW-1:0] popcnt(input logic [IW-1:0] v);
      logic [DW-1:0] c;
      c = '0;
      for (int i = 0; i < IW; i++) c = c + DW'(v[i]);
      return c;
   endfunction

   assign bit_cur = anf_q[idx];
   assign pc      = popcnt(idx);
   assign deg_nxt = (bit_cur && (pc > deg_q)) ? pc : deg_q;
   assign any_nxt = any_q | bit_cur;
   assign last    = (idx == IW'(W-1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SCAN;
         SCAN:    if (last)     state_nxt = DONE;
         DONE:    if (out_ack)  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         anf_q    <= '0;
         idx      <= '0;
         deg_q    <= '0;
         any_q    <= 1'b0;
         zero_q   <= 1'b0;
         affine_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               anf_q    <= anf;
               idx      <= '0;
               deg_q    <= '0;
               any_q    <= 1'b0;
               zero_q   <= 1'b0;
               affine_q <= 1'b0;
            end
            SCAN: begin
               // idx wraps to 0 naturally on the W-1 -> DONE step
               idx   <= idx + IW'(1);
               deg_q <= deg_nxt;
               any_q <= any_nxt;
               if (last) begin
                  zero_q   <= ~any_nxt;
                  affine_q <= (deg_nxt <= DW'(1));
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ZH_WEIGHT_EN
   logic [WW-1:0] weight_q;

   always_ff @(posedge clk) begin
      if (reset)                         weight_q <= '0;
      else if (state == IDLE && in_valid) weight_q <= '0;
      else if (state == SCAN && bit_cur)  weight_q <= weight_q + WW'(1);
   end

   assign weight = weight_q;
`else
   assign weight = '0;
`endif

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);
   assign degree    = deg_q;
   assign is_zero   = zero_q;
   assign is_affine = affine_q;

endmodule

// File: tb/tb_zh_anf_degree.sv
// Scoreboard bench for zh_anf_degree: stimulus pushes expected results, monitor pops on out_valid.
module tb_zh_anf_degree;

`ifdef ZH_WEIGHT_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, out_valid, out_ack;
   logic [0:7] anf;
   logic [1:0] degree;
   logic [3:0] weight;
   logic       is_zero, is_affine;

   typedef struct {
      int d;
      int w;
      int z;
      int a;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   nt  = 0;
   int   nf  = 0;
   int   cyc = 0;
   bit   prev_ov = 1'b0;

   zh_anf_degree dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .anf(anf),
      .out_valid(out_valid), .out_ack(out_ack), .degree(degree), .weight(weight),
      .is_zero(is_zero), .is_affine(is_affine)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      nt++;
      if (act != exp) begin
         nf++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: compare once per result, on the rising edge of out_valid
   always @(negedge clk) begin
      if (out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency",   cyc - e.acc, 8);
            chk("degree",    int'(degree), e.d);
            chk("weight",    int'(weight), e.w);
            chk("is_zero",   int'(is_zero), e.z);
            chk("is_affine", int'(is_affine), e.a);
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [0:7] v, input int d, input int w, input int z,
                       input int a, input int hold);
      int wexp;
      bit seen;
      wexp = WEN ? w : 0;
      @(negedge clk);
      anf = v; in_valid = 1'b1;
      chk("in_ready_idle", int'(in_ready), 1);
      @(posedge clk); #1;
      sb.push_back('{d, wexp, z, a, cyc});
      @(negedge clk);
      in_valid = 1'b0;
      anf = ~v;
      out_ack = 1'b1;          // stray ack while out_valid=0 must be ignored
      chk("in_ready_scan", int'(in_ready), 0);
      @(negedge clk);
      out_ack = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (out_valid) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) chk("out_valid_timeout", 0, 1);
      for (int h = 0; h < hold; h++) begin
         if (h == 5 || h == 6) begin anf = 8'h00; in_valid = 1'b1; end
         else in_valid = 1'b0;
         chk("bp_hold", {out_valid, in_ready, is_zero, is_affine, degree, weight},
             {1'b1, 1'b0, z[0], a[0], d[1:0], wexp[3:0]});
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      chk("ready_after_ack", {in_ready, out_valid}, 2'b10);
      chk("held_after_ack", {is_zero, is_affine, degree, weight},
          {z[0], a[0], d[1:0], wexp[3:0]});
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ack = 1'b0; anf = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  int'(in_ready), 0);
      chk("rst_outputs", {out_valid, is_zero, is_affine, degree, weight}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", int'(in_ready), 1);

      send(8'b10000000, 0, 1, 0, 1, 0);
      send(8'b00000000, 0, 0, 1, 1, 0);
      send(8'b01101000, 1, 3, 0, 1, 0);
      send(8'b00000001, 3, 1, 0, 0, 0);
      send(8'hFF,       3, 8, 0, 0, 20);

      // abort a scan with reset on its 4th cycle
      @(negedge clk);
      anf = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1 chk("in_ready_in_rst", int'(in_ready), 0);
      @(negedge clk);
      chk("abort_cleared", {out_valid, is_zero, is_affine, degree, weight}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_post_abort", int'(in_ready), 1);

      send(8'b00010110, 2, 3, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/zh_anf_degree.md
# zh_anf_degree

Downstream consumer of the 8-bit Zhegalkin (algebraic normal form) transform. It accepts one ANF coefficient vector per handshake and scans it serially, one coefficient per clock. It reports the algebraic degree, the monomial count, a zero flag and an affine flag. It feeds the function-classification logic that follows the transform.

## Interface
- N_VARS, default 3, number of Boolean variables. Vector width W = 2**N_VARS (8 at default).
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  anf is valid this cycle.
- in_ready  output  1  block can accept a vector. High only in IDLE and not in reset.
- anf  input  [0:W-1]  ANF coefficients. anf[i] is the coefficient of the monomial whose variables are the set bits of index i; anf[0] is the constant term.
- out_valid  output  1  result is valid. Held high until acknowledged.
- out_ack  input  1  consumer takes the result.
- degree  output  clog2(N_VARS+1) (2 at default)  maximum popcount(i) over all i with anf[i]=1. Reads 0 for the zero vector.
- weight  output  clog2(W+1) (4 at default)  number of ones in anf.
- is_zero  output  1  anf was all zeros.
- is_affine  output  1  degree <= 1 (includes the zero vector).

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture anf into an internal register, clear idx, degree, weight and the any-one flag, then go to SCAN.
- SCAN:
  - Each cycle examines coefficient idx of the captured vector.
  - If the bit is 1: degree = max(degree, popcount(idx)), weight += 1 and the any-one flag is set.
  - idx increments each cycle.
  - The cycle that processes idx = W-1 moves to DONE.
  - Input changes after capture do not affect the result.
- DONE:
  - out_valid=1.
  - is_zero = ~any-one; is_affine = (degree <= 1).
  - On out_ack, go to IDLE.
- Result registers (degree, weight, is_zero, is_affine) hold their values after out_ack. They change only when the next vector is captured. Consumers must qualify them with out_valid.
- in_valid outside IDLE is ignored; no capture takes place and no error is raised.
- out_ack while out_valid=0 is ignored.
- Arithmetic rules:
  - weight saturates at W by construction; no wrap.
  - idx is clog2(W) bits wide and wraps only on the transition to DONE.
- Reset, at any time including mid-SCAN:
  - State goes to IDLE and idx=0.
  - degree=0, weight=0, is_zero=0, is_affine=0, out_valid=0.
  - in_ready=0 while reset is high and 1 in the first cycle after reset is released.
  - An aborted scan produces no result.

## Timing
- Acceptance edge E0: in_valid & in_ready.
- Coefficients 0..W-1 are processed on edges E1..EW.
- out_valid rises after edge EW, i.e. W cycles after acceptance (8 at default).
- in_ready=0 from E0 until the edge where out_ack is sampled in DONE.
- in_ready=1 in the cycle after that edge.
- Minimum throughput: one vector every W+2 cycles (accept, W scan cycles, ack).
- out_valid and all results stay stable for any length of out_ack back-pressure.
- No combinational path from inputs to outputs. in_ready decodes state and reset only.

## Configuration
- Macro ZH_WEIGHT_EN.
- Defined: weight counter built, and weight reports the monomial count.
- Undefined: counter not built, and the weight port is driven constant 0.
- Degree, is_zero and is_affine are unaffected either way; is_zero always comes from the any-one flag.

## Test plan
- anf=8'b10000000 (constant 1), default N_VARS -> out_valid exactly 8 cycles after acceptance; degree=0, weight=1, is_zero=0, is_affine=1.
- anf=8'b00000000 -> degree=0, weight=0, is_zero=1, is_affine=1. Then anf=8'b01101000 (x0^x1^x2 terms) -> degree=1, weight=3, is_affine=1.
- anf=8'b00000001 (x0x1x2 only) -> degree=3, weight=1, is_affine=0. Then anf=8'hFF -> degree=3, weight=8, is_affine=0.
- Back-pressure: hold out_ack=0 for 20 cycles in DONE and pulse in_valid with a different vector -> outputs unchanged, in_ready=0, no capture. After out_ack, in_ready=1 on the next cycle.
- Reset asserted on the 4th SCAN cycle -> the next cycle shows state IDLE, out_valid=0 and all results 0. in_ready=1 after release, and a fresh vector yields a correct result.
- Build without ZH_WEIGHT_EN, anf=8'hFF -> weight=0, degree=3, is_zero=0.
